// File: rtl/rob_pkg.sv
// Shared widths, reserved tag values and tag arithmetic for the reorder buffer.
package rob_pkg;

    localparam int ROB_ADD_W = 4;
    localparam int REG_ADD_W = 5;
    localparam int REG_DAT_W = 32;
    localparam int INS_OP_W  = 6;
    localparam int ROB_N     = 2 ** ROB_ADD_W;

    typedef logic [ROB_ADD_W-1:0] tag_t;

    // Tag 0 means "operand already in the regfile", so it is never allocated.
    localparam tag_t TAG_NONE  = '0;
    localparam tag_t TAG_FIRST = tag_t'(1);
    localparam tag_t TAG_LAST  = tag_t'(ROB_N - 1);

    function automatic tag_t next_tag(input tag_t t);
        return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
    endfunction

endpackage

// File: rtl/rob_fwd.sv
// Combinational operand resolve: regfile value, committed-ready ROB entry, or same-cycle CDB bypass.
module rob_fwd
    import rob_pkg::*;
(
    input  logic [ROB_ADD_W-1:0] q,
    input  logic [REG_DAT_W-1:0] v,
    input  logic                 ent_ready,
    input  logic [REG_DAT_W-1:0] ent_val,
    input  logic                 cdb_en,
    input  logic [ROB_ADD_W-1:0] cdb_qn,
    input  logic [REG_DAT_W-1:0] cdb_v,
    output logic [ROB_ADD_W-1:0] q_res,
    output logic [REG_DAT_W-1:0] v_res
);

    always_comb begin
        q_res = q;
        v_res = v;
        if (q == TAG_NONE) begin
            q_res = TAG_NONE;
            v_res = v;
        end else if (ent_ready) begin
            q_res = TAG_NONE;
            v_res = ent_val;
        end else if (cdb_en && (cdb_qn == q)) begin
            q_res = TAG_NONE;
            v_res = cdb_v;
        end
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates rename tags, resolves and dispatches operands, captures CDB results
// and retires one entry per cycle in program order.
module rob
    import rob_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 iFlush,
    input  logic                 iIS_En,
    input  logic                 iIS_EnRd,
    input  logic [REG_ADD_W-1:0] iIS_Rd,
    output logic                 oIS_Full,
    output logic [ROB_ADD_W-1:0] oRF_Qn,
    input  logic                 iRF_En,
    input  logic [ROB_ADD_W-1:0] iRF_Qs1,
    input  logic [ROB_ADD_W-1:0] iRF_Qs2,
    input  logic [REG_DAT_W-1:0] iRF_Vs1,
    input  logic [REG_DAT_W-1:0] iRF_Vs2,
    input  logic [INS_OP_W-1:0]  iRF_Op,
    input  logic [REG_DAT_W-1:0] iRF_Pc,
    input  logic [REG_DAT_W-1:0] iRF_Imm,
    input  logic                 iCDB_En,
    input  logic [ROB_ADD_W-1:0] iCDB_Qn,
    input  logic [REG_DAT_W-1:0] iCDB_V,
    output logic                 oRS_En,
    output logic [ROB_ADD_W-1:0] oRS_Qn,
    output logic [ROB_ADD_W-1:0] oRS_Qj,
    output logic [ROB_ADD_W-1:0] oRS_Qk,
    output logic [REG_DAT_W-1:0] oRS_Vj,
    output logic [REG_DAT_W-1:0] oRS_Vk,
    output logic [INS_OP_W-1:0]  oRS_Op,
    output logic [REG_DAT_W-1:0] oRS_Pc,
    output logic [REG_DAT_W-1:0] oRS_Imm,
    output logic                 oRF_En,
    output logic [REG_ADD_W-1:0] oRF_Rd,
    output logic [REG_DAT_W-1:0] oRF_Vd,
    output logic [ROB_ADD_W-1:0] oRF_Qd
);

    logic [ROB_N-1:0]     busy;
    logic [ROB_N-1:0]     ready;
    logic [ROB_N-1:0]     en_rd;
    logic [REG_ADD_W-1:0] rd_q  [ROB_N];
    logic [REG_DAT_W-1:0] val_q [ROB_N];

    logic [ROB_ADD_W-1:0] alloc_ptr;
    logic [ROB_ADD_W-1:0] head_ptr;
    logic [ROB_ADD_W-1:0] fill_ptr;
    logic [ROB_ADD_W-1:0] count;

    logic                 do_alloc;
    logic                 do_commit;
    logic [ROB_ADD_W-1:0] qj_res;
    logic [ROB_ADD_W-1:0] qk_res;
    logic [REG_DAT_W-1:0] vj_res;
    logic [REG_DAT_W-1:0] vk_res;

    assign oIS_Full  = (count == TAG_LAST);
    assign oRF_Qn    = alloc_ptr;
    assign do_alloc  = iIS_En & ~oIS_Full;
    assign do_commit = busy[head_ptr] & ready[head_ptr];

    rob_fwd u_fwd_j (
        .q         (iRF_Qs1),
        .v         (iRF_Vs1),
        .ent_ready (ready[iRF_Qs1]),
        .ent_val   (val_q[iRF_Qs1]),
        .cdb_en    (iCDB_En),
        .cdb_qn    (iCDB_Qn),
        .cdb_v     (iCDB_V),
        .q_res     (qj_res),
        .v_res     (vj_res)
    );

    rob_fwd u_fwd_k (
        .q         (iRF_Qs2),
        .v         (iRF_Vs2),
        .ent_ready (ready[iRF_Qs2]),
        .ent_val   (val_q[iRF_Qs2]),
        .cdb_en    (iCDB_En),
        .cdb_qn    (iCDB_Qn),
        .cdb_v     (iCDB_V),
        .q_res     (qk_res),
        .v_res     (vk_res)
    );

    // Strobes are single-cycle pulses; a frozen (en=0) edge still drops them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            ready     <= '0;
            en_rd     <= '0;
            for (int i = 0; i < ROB_N; i++) begin
                rd_q[i]  <= '0;
                val_q[i] <= '0;
            end
            alloc_ptr <= TAG_FIRST;
            head_ptr  <= TAG_FIRST;
            fill_ptr  <= TAG_FIRST;
            count     <= '0;
            oRS_En    <= 1'b0;
            oRS_Qn    <= '0;
            oRS_Qj    <= '0;
            oRS_Qk    <= '0;
            oRS_Vj    <= '0;
            oRS_Vk    <= '0;
            oRS_Op    <= '0;
            oRS_Pc    <= '0;
            oRS_Imm   <= '0;
            oRF_En    <= 1'b0;
            oRF_Rd    <= '0;
            oRF_Vd    <= '0;
            oRF_Qd    <= '0;
        end else begin
            oRS_En <= 1'b0;
            oRF_En <= 1'b0;
            if (en) begin
                if (iFlush) begin
                    busy      <= '0;
                    ready     <= '0;
                    alloc_ptr <= TAG_FIRST;
                    head_ptr  <= TAG_FIRST;
                    fill_ptr  <= TAG_FIRST;
                    count     <= '0;
                end else begin
                    if (iCDB_En && busy[iCDB_Qn]) begin
                        ready[iCDB_Qn] <= 1'b1;
                        val_q[iCDB_Qn] <= iCDB_V;
                    end
                    if (do_commit) begin
                        oRF_En          <= en_rd[head_ptr];
                        oRF_Rd          <= rd_q[head_ptr];
                        oRF_Vd          <= val_q[head_ptr];
                        oRF_Qd          <= head_ptr;
                        busy[head_ptr]  <= 1'b0;
                        ready[head_ptr] <= 1'b0;
                        head_ptr        <= next_tag(head_ptr);
                    end
                    if (do_alloc) begin
                        busy[alloc_ptr]  <= 1'b1;
                        ready[alloc_ptr] <= 1'b0;
                        en_rd[alloc_ptr] <= iIS_EnRd;
                        rd_q[alloc_ptr]  <= iIS_Rd;
                        alloc_ptr        <= next_tag(alloc_ptr);
                    end
                    // Operand packets arrive in issue order, so a single fill pointer names their entry.
                    if (iRF_En) begin
                        oRS_En   <= 1'b1;
                        oRS_Qn   <= fill_ptr;
                        oRS_Qj   <= qj_res;
                        oRS_Qk   <= qk_res;
                        oRS_Vj   <= vj_res;
                        oRS_Vk   <= vk_res;
                        oRS_Op   <= iRF_Op;
                        oRS_Pc   <= iRF_Pc;
                        oRS_Imm  <= iRF_Imm;
                        fill_ptr <= next_tag(fill_ptr);
                    end
                    case ({do_alloc, do_commit})
                        2'b10:   count <= count + TAG_FIRST;
                        2'b01:   count <= count - TAG_FIRST;
                        default: count <= count;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed vector table, corner-case sequences and a random run
// compared against a queue-based reference model.
module tb_rob;
    import rob_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en, iFlush, iIS_En, iIS_EnRd, iRF_En, iCDB_En;
    logic [REG_ADD_W-1:0] iIS_Rd;
    logic [ROB_ADD_W-1:0] iRF_Qs1, iRF_Qs2, iCDB_Qn;
    logic [REG_DAT_W-1:0] iRF_Vs1, iRF_Vs2, iRF_Pc, iRF_Imm, iCDB_V;
    logic [INS_OP_W-1:0]  iRF_Op;
    logic                 oIS_Full, oRS_En, oRF_En;
    logic [ROB_ADD_W-1:0] oRF_Qn, oRS_Qn, oRS_Qj, oRS_Qk, oRF_Qd;
    logic [REG_DAT_W-1:0] oRS_Vj, oRS_Vk, oRS_Pc, oRS_Imm, oRF_Vd;
    logic [INS_OP_W-1:0]  oRS_Op;
    logic [REG_ADD_W-1:0] oRF_Rd;

    always #5 clk = ~clk;

    rob dut (
        .clk(clk), .rst_n(rst_n), .en(en), .iFlush(iFlush),
        .iIS_En(iIS_En), .iIS_EnRd(iIS_EnRd), .iIS_Rd(iIS_Rd),
        .oIS_Full(oIS_Full), .oRF_Qn(oRF_Qn),
        .iRF_En(iRF_En), .iRF_Qs1(iRF_Qs1), .iRF_Qs2(iRF_Qs2),
        .iRF_Vs1(iRF_Vs1), .iRF_Vs2(iRF_Vs2), .iRF_Op(iRF_Op), .iRF_Pc(iRF_Pc), .iRF_Imm(iRF_Imm),
        .iCDB_En(iCDB_En), .iCDB_Qn(iCDB_Qn), .iCDB_V(iCDB_V),
        .oRS_En(oRS_En), .oRS_Qn(oRS_Qn), .oRS_Qj(oRS_Qj), .oRS_Qk(oRS_Qk),
        .oRS_Vj(oRS_Vj), .oRS_Vk(oRS_Vk), .oRS_Op(oRS_Op), .oRS_Pc(oRS_Pc), .oRS_Imm(oRS_Imm),
        .oRF_En(oRF_En), .oRF_Rd(oRF_Rd), .oRF_Vd(oRF_Vd), .oRF_Qd(oRF_Qd)
    );

    typedef struct {
        logic        en, flush, is_en, is_enrd, rf_en, cdb_en;
        logic [4:0]  is_rd;
        logic [3:0]  qs1, qs2, cdb_qn;
        logic [31:0] vs1, vs2, pc, imm, cdb_v;
        logic [5:0]  op;
    } stim_t;

    typedef struct {
        logic        rs_en, rf_en, full;
        logic [3:0]  rs_qn, qj, qk, rf_qd, qn;
        logic [31:0] vj, vk, pc, imm, rf_vd;
        logic [5:0]  op;
        logic [4:0]  rf_rd;
    } exp_t;

    typedef struct {
        int en, flush, is_en, is_enrd, is_rd, rf_en, qs1, vs1, qs2, vs2, cdb_en, cdb_qn, cdb_v;
        int x_rs_en, x_rs_qn, x_qj, x_vj, x_qk, x_vk, x_rf_en, x_rf_rd, x_rf_vd, x_rf_qd, x_qn, x_full;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic        en_rd;
        logic        ready;
        logic [31:0] val;
    } ment_t;

    // Reference model: in-flight instructions in program order plus the tag counters.
    ment_t mq[$];
    int    alloc_tag, fill_tag, pending;
    exp_t  ex;
    int    passed = 0;
    int    total  = 0;
    stim_t s;
    vec_t  tbl [11];

    function automatic int nxt(input int t);
        return (t % 15) + 1;
    endfunction

    function automatic stim_t idleStim();
        stim_t r;
        r = '{default: '0};
        r.en = 1'b1;
        return r;
    endfunction

    function automatic bit tagReady(input logic [3:0] t);
        foreach (mq[i]) if (mq[i].tag == t && mq[i].ready) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, expv);
    endtask

    task automatic checkOutput(input exp_t e, input string ctx);
        check({ctx, ".rs_en"}, oRS_En, e.rs_en);
        check({ctx, ".rs_qn"}, oRS_Qn, e.rs_qn);
        check({ctx, ".rs_qj"}, oRS_Qj, e.qj);
        check({ctx, ".rs_vj"}, oRS_Vj, e.vj);
        check({ctx, ".rs_qk"}, oRS_Qk, e.qk);
        check({ctx, ".rs_vk"}, oRS_Vk, e.vk);
        check({ctx, ".rs_op_pc_imm"}, {oRS_Op, oRS_Pc, oRS_Imm}, {e.op, e.pc, e.imm});
        check({ctx, ".rf_en"}, oRF_En, e.rf_en);
        check({ctx, ".rf_rd"}, oRF_Rd, e.rf_rd);
        check({ctx, ".rf_vd"}, oRF_Vd, e.rf_vd);
        check({ctx, ".rf_qd"}, oRF_Qd, e.rf_qd);
        check({ctx, ".rf_qn"}, oRF_Qn, e.qn);
        check({ctx, ".is_full"}, oIS_Full, e.full);
    endtask

    task automatic modelReset();
        ex = '{default: '0};
        ex.qn = 4'd1;
        mq.delete();
        alloc_tag = 1;
        fill_tag  = 1;
        pending   = 0;
    endtask

    task automatic resolve(input logic [3:0] q, input logic [31:0] v, input stim_t st,
                           output logic [3:0] qo, output logic [31:0] vo);
        bit hit;
        hit = 1'b0;
        qo  = q;
        vo  = v;
        if (q != 4'd0) begin
            foreach (mq[i]) if (mq[i].tag == q && mq[i].ready) begin
                qo = 4'd0; vo = mq[i].val; hit = 1'b1;
            end
            if (!hit && st.cdb_en && st.cdb_qn == q) begin
                qo = 4'd0; vo = st.cdb_v;
            end
        end else begin
            qo = 4'd0;
        end
    endtask

    task automatic modelStep(input stim_t st);
        int          pre;
        bit          commit;
        logic [3:0]  q;
        logic [31:0] v;
        ex.rs_en = 1'b0;
        ex.rf_en = 1'b0;
        if (!st.en) return;
        if (st.flush) begin
            mq.delete();
            alloc_tag = 1; fill_tag = 1; pending = 0;
            ex.qn = 4'd1; ex.full = 1'b0;
            return;
        end
        pre = mq.size();
        if (st.rf_en) begin
            ex.rs_en = 1'b1;
            ex.rs_qn = 4'(fill_tag);
            resolve(st.qs1, st.vs1, st, q, v); ex.qj = q; ex.vj = v;
            resolve(st.qs2, st.vs2, st, q, v); ex.qk = q; ex.vk = v;
            ex.op = st.op; ex.pc = st.pc; ex.imm = st.imm;
            fill_tag = nxt(fill_tag);
            if (pending > 0) pending--;
        end
        commit = (pre > 0) ? mq[0].ready : 1'b0;
        if (commit) begin
            ex.rf_en = mq[0].en_rd;
            ex.rf_rd = mq[0].rd;
            ex.rf_vd = mq[0].val;
            ex.rf_qd = mq[0].tag;
        end
        if (st.cdb_en) foreach (mq[i]) if (mq[i].tag == st.cdb_qn) begin
            mq[i].ready = 1'b1; mq[i].val = st.cdb_v;
        end
        if (commit) void'(mq.pop_front());
        if (st.is_en && pre < 15) begin
            mq.push_back('{tag: 4'(alloc_tag), rd: st.is_rd, en_rd: st.is_enrd, ready: 1'b0, val: 32'h0});
            alloc_tag = nxt(alloc_tag);
            pending++;
        end
        ex.qn   = 4'(alloc_tag);
        ex.full = (mq.size() == 15);
    endtask

    task automatic applyStimulus(input stim_t st);
        en = st.en; iFlush = st.flush;
        iIS_En = st.is_en; iIS_EnRd = st.is_enrd; iIS_Rd = st.is_rd;
        iRF_En = st.rf_en; iRF_Qs1 = st.qs1; iRF_Qs2 = st.qs2; iRF_Vs1 = st.vs1; iRF_Vs2 = st.vs2;
        iRF_Op = st.op; iRF_Pc = st.pc; iRF_Imm = st.imm;
        iCDB_En = st.cdb_en; iCDB_Qn = st.cdb_qn; iCDB_V = st.cdb_v;
        modelStep(st);
        @(posedge clk);
        #1;
        checkOutput(ex, "model");
    endtask

    task automatic doReset();
        stim_t r;
        r = idleStim();
        r.en = 1'b0;
        rst_n = 1'b0;
        en = r.en; iFlush = 0; iIS_En = 0; iIS_EnRd = 0; iIS_Rd = 0; iRF_En = 0;
        iRF_Qs1 = 0; iRF_Qs2 = 0; iRF_Vs1 = 0; iRF_Vs2 = 0; iRF_Op = 0; iRF_Pc = 0; iRF_Imm = 0;
        iCDB_En = 0; iCDB_Qn = 0; iCDB_V = 0;
        modelReset();
        @(negedge clk);
        checkOutput(ex, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd);
        stim_t r;
        r = idleStim(); r.is_en = 1'b1; r.is_enrd = 1'b1; r.is_rd = 5'(rd);
        applyStimulus(r);
    endtask

    task automatic cdb(input int tag, input int val);
        stim_t r;
        r = idleStim(); r.cdb_en = 1'b1; r.cdb_qn = 4'(tag); r.cdb_v = 32'(val);
        applyStimulus(r);
    endtask

    initial begin
        tbl[0]  = '{1,0, 1,1,1, 0, 0,0,0,0,          0,0,0,      0,0,0,0,0,0,          0,0,0,0,     2,0};
        tbl[1]  = '{1,0, 1,1,2, 1, 0,'h10,0,'h20,    0,0,0,      1,1,0,'h10,0,'h20,    0,0,0,0,     3,0};
        tbl[2]  = '{1,0, 1,1,3, 1, 1,'hDEAD,3,'h77,  1,1,'h55,   1,2,0,'h55,3,'h77,    0,0,0,0,     4,0};
        tbl[3]  = '{1,0, 0,0,0, 1, 1,0,2,'h99,       0,0,0,      1,3,0,'h55,2,'h99,    1,1,'h55,1,  4,0};
        tbl[4]  = '{1,0, 1,0,4, 0, 0,0,0,0,          1,2,'h66,   0,3,0,'h55,2,'h99,    0,1,'h55,1,  5,0};
        tbl[5]  = '{1,0, 0,0,0, 1, 3,1,3,2,          1,3,'hAB,   1,4,0,'hAB,0,'hAB,    1,2,'h66,2,  5,0};
        tbl[6]  = '{1,0, 0,0,0, 0, 0,0,0,0,          0,0,0,      0,4,0,'hAB,0,'hAB,    1,3,'hAB,3,  5,0};
        tbl[7]  = '{1,0, 0,0,0, 0, 0,0,0,0,          1,4,'h44,   0,4,0,'hAB,0,'hAB,    0,3,'hAB,3,  5,0};
        tbl[8]  = '{1,0, 0,0,0, 0, 0,0,0,0,          0,0,0,      0,4,0,'hAB,0,'hAB,    0,4,'h44,4,  5,0};
        tbl[9]  = '{1,0, 0,0,0, 0, 0,0,0,0,          1,9,'h999,  0,4,0,'hAB,0,'hAB,    0,4,'h44,4,  5,0};
        tbl[10] = '{0,0, 1,1,7, 1, 0,0,0,0,          1,5,'h5,    0,4,0,'hAB,0,'hAB,    0,4,'h44,4,  5,0};

        doReset();

        // Directed vectors: forwarding from ready entry, CDB bypass, unresolved tags, in-order commit.
        for (int i = 0; i < 11; i++) begin
            s = idleStim();
            s.en = 1'(tbl[i].en); s.flush = 1'(tbl[i].flush);
            s.is_en = 1'(tbl[i].is_en); s.is_enrd = 1'(tbl[i].is_enrd); s.is_rd = 5'(tbl[i].is_rd);
            s.rf_en = 1'(tbl[i].rf_en); s.qs1 = 4'(tbl[i].qs1); s.vs1 = 32'(tbl[i].vs1);
            s.qs2 = 4'(tbl[i].qs2); s.vs2 = 32'(tbl[i].vs2);
            s.cdb_en = 1'(tbl[i].cdb_en); s.cdb_qn = 4'(tbl[i].cdb_qn); s.cdb_v = 32'(tbl[i].cdb_v);
            applyStimulus(s);
            check($sformatf("tbl%0d.rs_en", i), oRS_En, tbl[i].x_rs_en);
            check($sformatf("tbl%0d.rs_qn", i), oRS_Qn, tbl[i].x_rs_qn);
            check($sformatf("tbl%0d.qj", i), oRS_Qj, tbl[i].x_qj);
            check($sformatf("tbl%0d.vj", i), oRS_Vj, tbl[i].x_vj);
            check($sformatf("tbl%0d.qk", i), oRS_Qk, tbl[i].x_qk);
            check($sformatf("tbl%0d.vk", i), oRS_Vk, tbl[i].x_vk);
            check($sformatf("tbl%0d.rf_en", i), oRF_En, tbl[i].x_rf_en);
            check($sformatf("tbl%0d.rf_rd", i), oRF_Rd, tbl[i].x_rf_rd);
            check($sformatf("tbl%0d.rf_vd", i), oRF_Vd, tbl[i].x_rf_vd);
            check($sformatf("tbl%0d.rf_qd", i), oRF_Qd, tbl[i].x_rf_qd);
            check($sformatf("tbl%0d.qn", i), oRF_Qn, tbl[i].x_qn);
            check($sformatf("tbl%0d.full", i), oIS_Full, tbl[i].x_full);
        end

        // Fill all 15 tags, then confirm a 16th issue is dropped until tag 1 commits.
        doReset();
        for (int i = 0; i < 15; i++) issue(i + 1);
        check("full_after_15", oIS_Full, 1);
        check("full_qn_wrapped", oRF_Qn, 1);
        issue(20);
        check("full_16th_qn", oRF_Qn, 1);
        check("full_16th_still_full", oIS_Full, 1);
        cdb(1, 'hC0DE);
        check("full_cdb_edge", oIS_Full, 1);
        s = idleStim(); applyStimulus(s);
        check("full_commit_qd", oRF_Qd, 1);
        check("full_commit_vd", oRF_Vd, 'hC0DE);
        check("full_dropped", oIS_Full, 0);
        issue(21);
        check("full_again", oIS_Full, 1);

        // Wrap: 20 issue/result/commit triples walk the tags 1..15,1..5.
        doReset();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap%0d.qn", i), oRF_Qn, nxt(i) == 0 ? 0 : (i % 15) + 1);
            issue(i);
            s = idleStim(); s.rf_en = 1'b1; s.cdb_en = 1'b1;
            s.cdb_qn = 4'((i % 15) + 1); s.cdb_v = 32'h1000 + 32'(i);
            applyStimulus(s);
            s = idleStim(); applyStimulus(s);
            check($sformatf("wrap%0d.qd", i), oRF_Qd, (i % 15) + 1);
            check($sformatf("wrap%0d.vd", i), oRF_Vd, 32'h1000 + 32'(i));
        end

        // Out-of-order completion still retires in program order; then squash everything.
        doReset();
        issue(1);
        issue(2);
        cdb(2, 'h22);
        check("ooo_no_commit_a", oRF_En, 0);
        s = idleStim(); applyStimulus(s);
        check("ooo_no_commit_b", oRF_En, 0);
        cdb(1, 'h11);
        check("ooo_no_commit_c", oRF_En, 0);
        s = idleStim(); applyStimulus(s);
        check("ooo_first_qd", oRF_Qd, 1);
        check("ooo_first_en", oRF_En, 1);
        s = idleStim(); applyStimulus(s);
        check("ooo_second_qd", oRF_Qd, 2);
        check("ooo_second_vd", oRF_Vd, 'h22);
        issue(3);
        issue(4);
        s = idleStim(); s.flush = 1'b1; s.is_en = 1'b1; s.cdb_en = 1'b1; s.cdb_qn = 4'd3;
        applyStimulus(s);
        check("flush_qn", oRF_Qn, 1);
        check("flush_full", oIS_Full, 0);

        // Reset asserted between edges clears every output at once.
        issue(9);
        issue(10);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput(ex, "async_rst");
        doReset();

        // Random traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            s = idleStim();
            s.en      = ($urandom_range(0, 9) != 0);
            s.flush   = ($urandom_range(0, 99) == 0);
            s.is_en   = ($urandom_range(0, 2) != 0);
            s.is_enrd = ($urandom_range(0, 3) != 0);
            s.is_rd   = 5'($urandom);
            if (pending > 0 && $urandom_range(0, 3) != 0) begin
                s.rf_en = 1'b1;
                s.qs1 = ($urandom_range(0, 2) == 0) ? 4'd0 :
                        (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                                     : 4'($urandom_range(0, 15));
                s.qs2 = ($urandom_range(0, 2) == 0) ? 4'd0 :
                        (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                                     : 4'($urandom_range(0, 15));
                s.vs1 = $urandom; s.vs2 = $urandom;
                s.op = 6'($urandom); s.pc = $urandom; s.imm = $urandom;
            end
            if ($urandom_range(0, 1) == 1) begin
                s.cdb_qn = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                                        : 4'($urandom_range(0, 15));
                s.cdb_en = !tagReady(s.cdb_qn);
                s.cdb_v  = $urandom;
            end
            applyStimulus(s);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
